rng: RTL and testbench
======================

// Module: rng
// PURPOSE
//  Free-running 32-bit pseudo-random number generator (xorshift32).
//  One new value per clock after reset is released; no enable/handshake.
//  Shared random source for game logic (spawn positions, events).
//  Not cryptographic; sequence is fully determined by SEED.
// PARAMETERS
//  SEED  32'hACE1_2463  reset state; if 0, 32'h0000_0001 is loaded instead
//  SH_A  13             first left-shift amount
//  SH_B  17             right-shift amount
//  SH_C  5              second left-shift amount
// PORTS
//  clk_in       in   1   system clock; all state changes on rising edge
//  rst_in       in   1   synchronous reset, active-low (0 = reset)
//  shifted_res  out  32  current generator state = random output (registered)
// BEHAVIOUR
//  - Single 32-bit state register drives shifted_res directly (no comb path).
//  - Reset: rst_in==0 at a rising edge -> state <= (SEED!=0 ? SEED : 32'h1).
//    Held while rst_in stays 0. Reset wins over stepping in the same edge.
//  - Step: rst_in==1 at a rising edge -> state <= f(state). f:
//      t1 = s  ^ (s  << SH_A);  t2 = t1 ^ (t1 >> SH_B);
//      f  = t2 ^ (t2 << SH_C);  logical shifts, all 32-bit, overflow dropped.
//  - Latency: first non-seed value appears 1 clock after rst_in rises.
//  - Whole step completes in one cycle; no pipeline, no valid signal.
//  - Zero lock-up: state 0 is a fixed point; if state ever reads 0
//    (e.g. via X-clean-up or bad SEED), next edge loads 32'h1 instead of f(0).
//  - With default shifts the non-zero period is 2^32-1; output never 0.
//  - Reset mid-operation: restart from seed on the next edge; sequence
//    after release is identical to the one after the first reset.
//  - Power-up value before first reset is don't-care.
// TESTING
//  1 SEED=1: hold rst_in=0 several cycles -> shifted_res==32'h0000_0001
//    every cycle.
//  2 SEED=1: release rst_in -> after edge 1 shifted_res==32'h0004_2021,
//    after edge 2 ==32'h0408_0601 (67634689).
//  3 SEED=1: run 20 steps, assert rst_in=0 for one edge -> output back to
//    32'h1; on release, steps reproduce 32'h0004_2021, 32'h0408_0601.
//  4 SEED=0: reset -> shifted_res==32'h1; first step -> 32'h0004_2021.
//  5 Default SEED: run 100000 cycles -> shifted_res never 0, never X, and
//    never equal to SEED after the first step.
//  6 Compare every cycle against a behavioural xorshift32 model with the
//    same SH_A/SH_B/SH_C; any mismatch fails.

Source files
------------

// File: rtl/rng.sv
// Free-running xorshift32 generator: one new 32-bit value per clock, seeded on reset.
// The state register is the output, so shifted_res has no combinational path.
module rng #(
  parameter logic [31:0] SEED = 32'hACE1_2463,
  parameter int unsigned SH_A = 13,
  parameter int unsigned SH_B = 17,
  parameter int unsigned SH_C = 5
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [31:0] shifted_res
);

  // A zero seed would lock the generator at its fixed point, so substitute 1.
  localparam logic [31:0] RST_VAL = (SEED != 32'h0) ? SEED : 32'h0000_0001;

  logic [31:0] state_q;
  logic [31:0] state_d;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s ^ (s << SH_A);
    t2 = t1 ^ (t1 >> SH_B);
    return t2 ^ (t2 << SH_C);
  endfunction

  // Escape the zero fixed point instead of stepping it.
  always_comb begin
    state_d = xorshift32(state_q);
    if (state_q == 32'h0) begin
      state_d = 32'h0000_0001;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

  assign shifted_res = state_q;

endmodule

// File: tb/tb_rng.sv
// Scoreboard bench for rng: three instances (SEED=1, SEED=0, default seed) share
// clock and reset; stimulus queues expected outputs, a monitor pops and compares.
module tb_rng;

  localparam logic [31:0] DEF_SEED = 32'hACE1_2463;
  localparam int          RUN_CYC  = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] out1;
  logic [31:0] out0;
  logic [31:0] outd;

  always #5 clk = ~clk;

  rng #(.SEED(32'h0000_0001)) dut1 (.clk_in(clk), .rst_in(rst), .shifted_res(out1));
  rng #(.SEED(32'h0000_0000)) dut0 (.clk_in(clk), .rst_in(rst), .shifted_res(out0));
  rng                         dutd (.clk_in(clk), .rst_in(rst), .shifted_res(outd));

  typedef struct packed {
    logic [31:0] e1;
    logic [31:0] e0;
    logic [31:0] ed;
    logic        chk_seed;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference xorshift32 with shifts 13/17/5.
  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] a;
    if (s == 32'h0) return 32'h0000_0001;
    a = s ^ {s[18:0], 13'b0};
    a = a ^ {17'b0, a[31:17]};
    a = a ^ {a[26:0], 5'b0};
    return a;
  endfunction

  logic [31:0] md;

  task automatic push(input logic [31:0] e1, input logic [31:0] e0,
                      input logic [31:0] ed, input logic chk_seed);
    exp_t e;
    e.e1 = e1; e.e0 = e0; e.ed = ed; e.chk_seed = chk_seed;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the generator presents a value every cycle, so pop once per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seed1", out1, e.e1);
        check("seed0", out0, e.e0);
        check("seeddef", outd, e.ed);
        if (e.chk_seed) begin
          n_checks++;
          if ($isunknown(outd) || outd == 32'h0 || outd == DEF_SEED) begin
            n_fail++;
            $display("FAIL def_range: got %08h expected nonzero, known, not %08h", outd, DEF_SEED);
          end
        end
      end
    end
  end

  // Stimulus: each setting applied before an edge queues what that edge must produce.
  initial begin
    logic [31:0] m1;
    int          wait_cyc;

    rst = 1'b0;
    push(32'h1, 32'h1, DEF_SEED, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      push(32'h1, 32'h1, DEF_SEED, 1'b0);
    end

    // Release: first two hand-computed steps from state 1.
    md = DEF_SEED;
    @(negedge clk); rst = 1'b1; md = model_step(md);
    push(32'h0004_2021, 32'h0004_2021, md, 1'b1);
    @(negedge clk); md = model_step(md);
    push(32'h0408_0601, 32'h0408_0601, md, 1'b1);
    m1 = 32'h0408_0601;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      m1 = model_step(m1); md = model_step(md);
      push(m1, m1, md, 1'b1);
    end

    // Single-edge reset mid-run, then the sequence must restart identically.
    @(negedge clk); rst = 1'b0; md = DEF_SEED;
    push(32'h1, 32'h1, DEF_SEED, 1'b0);
    @(negedge clk); rst = 1'b1; md = model_step(md);
    push(32'h0004_2021, 32'h0004_2021, md, 1'b1);
    @(negedge clk); md = model_step(md);
    push(32'h0408_0601, 32'h0408_0601, md, 1'b1);
    m1 = 32'h0408_0601;

    for (int i = 0; i < RUN_CYC; i++) begin
      @(negedge clk);
      m1 = model_step(m1); md = model_step(md);
      push(m1, m1, md, 1'b1);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
